// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FSM state encoding, PC increment, NOP and default halt encodings.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } ifu_state_e;

  localparam logic [31:0] PC_INCR           = 32'd4;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter register with next-PC selection (redirect > increment > hold),
// word alignment of redirect targets and wrap modulo the instruction memory span.
module ifu_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        load_i,
  input  logic        inc_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  localparam logic [31:0] SPAN = 32'(IMEM_WORDS) * PC_INCR;

  function automatic logic [31:0] wrap_addr(input logic [31:0] a);
    return a % SPAN;
  endfunction

  logic [31:0] pc_q, pc_d;

  assign pc_o       = pc_q;
  // Unwrapped sum; the IF/ID stage records this value as-is.
  assign pc_plus4_o = pc_q + PC_INCR;

  always_comb begin
    pc_d = pc_q;
    if (load_i)
      pc_d = wrap_addr(target_i & ~32'h0000_0003);
    else if (inc_i)
      pc_d = wrap_addr(pc_plus4_o);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: BOOT/RUN/HALTED control, IF/ID register, stall/flush/redirect handling.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128,
  parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  output logic        Halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        vld_q, vld_d;
  logic        pc_load, pc_inc, capture, bubble;
  logic [31:0] pc, pc_plus4;

  ifu_pc_reg #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc (
    .Clk        (Clk),
    .Rst        (Rst),
    .load_i     (pc_load),
    .inc_i      (pc_inc),
    .target_i   (BranchTarget),
    .pc_o       (pc),
    .pc_plus4_o (pc_plus4)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    vld_d   = vld_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        bubble = PCSrc | Flush | Stall;
        if (PCSrc) begin
          pc_load = 1'b1;
          vld_d   = 1'b0;
        end else if (Flush) begin
          vld_d   = 1'b0;
          pc_inc  = ~Stall;
        end else if (!Stall) begin
          capture = 1'b1;
          instr_d = ImemData;
          pcp4_d  = pc_plus4;
          vld_d   = 1'b1;
          // The halt word is still delivered downstream, but the PC parks on it.
          if (ImemData == HALT_WORD) state_d = ST_HALTED;
          else                       pc_inc  = 1'b1;
        end
      end
      ST_HALTED: begin
        vld_d = 1'b0;
        if (PCSrc) begin
          pc_load = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_BOOT;
      instr_q <= NOP_WORD;
      pcp4_q  <= 32'h0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      vld_q   <= vld_d;
    end
  end

  assign ImemAddr    = pc;
  assign Instruction = instr_q;
  assign PCPlus4     = pcp4_q;
  assign InstrValid  = vld_q;
  assign Halted      = (state_q == ST_HALTED);

`ifdef IFU_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (capture) fetch_cnt_q  <= sat_inc(fetch_cnt_q);
      if (bubble)  bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = capture ^ bubble;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus halt, reset and wrap sequences.
module tb_instruction_fetch_unit;
  logic        Clk = 1'b0;
  logic        Rst, Stall, Flush, PCSrc;
  logic [31:0] BranchTarget, ImemAddr, ImemData, Instruction, PCPlus4;
  logic        InstrValid, Halted;
  logic [31:0] mem [0:127];

  logic        Rst2;
  logic        Stall2 = 1'b0, Flush2 = 1'b0, PCSrc2 = 1'b0;
  logic [31:0] BranchTarget2 = 32'h0;
  logic [31:0] ImemAddr2, ImemData2, Instruction2, PCPlus42;
  logic        InstrValid2, Halted2;
  logic [31:0] mem2 [0:3];
`ifdef IFU_PERF_CNT_EN
  logic [31:0] FetchCount, BubbleCount, FetchCount2, BubbleCount2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  assign ImemData  = mem[ImemAddr[8:2]];
  assign ImemData2 = mem2[ImemAddr2[3:2]];

  instruction_fetch_unit #(.IMEM_WORDS(128)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .Instruction(Instruction), .PCPlus4(PCPlus4), .InstrValid(InstrValid),
    .Halted(Halted)
`ifdef IFU_PERF_CNT_EN
    , .FetchCount(FetchCount), .BubbleCount(BubbleCount)
`endif
  );

  instruction_fetch_unit #(.IMEM_WORDS(4)) dut_wrap (
    .Clk(Clk), .Rst(Rst2), .Stall(Stall2), .Flush(Flush2), .PCSrc(PCSrc2),
    .BranchTarget(BranchTarget2), .ImemAddr(ImemAddr2), .ImemData(ImemData2),
    .Instruction(Instruction2), .PCPlus4(PCPlus42), .InstrValid(InstrValid2),
    .Halted(Halted2)
`ifdef IFU_PERF_CNT_EN
    , .FetchCount(FetchCount2), .BubbleCount(BubbleCount2)
`endif
  );

  typedef struct {
    logic        stall, flush, pcsrc;
    logic [31:0] target;
    logic [31:0] addr, instr, pcp4;
    logic        vld;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [31:0] m(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic p, input logic [31:0] t);
    Stall = s; Flush = f; PCSrc = p; BranchTarget = t;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] ins,
                         input logic [31:0] p4, input logic v, input logic h);
    chk({tag, " ImemAddr"}, ImemAddr, a);
    chk({tag, " Instruction"}, Instruction, ins);
    chk({tag, " PCPlus4"}, PCPlus4, p4);
    chk({tag, " InstrValid"}, 32'(InstrValid), 32'(v));
    chk({tag, " Halted"}, 32'(Halted), 32'(h));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = m(i);
    for (int i = 0; i < 4; i++) mem2[i] = 32'hB000_0000 | 32'(i);
    Rst = 1'b0; Rst2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,  32'h0,   1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h4,   m(0),   32'h4,   1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h8,   m(1),   32'h8,   1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h8,   m(1),   32'h8,   1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h8,   m(1),   32'h8,   1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h8,   m(1),   32'h8,   1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'hC,   m(2),   32'hC,   1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h10,  m(2),   32'hC,   1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h10,  m(2),   32'hC,   1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h14,  m(4),   32'h14,  1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h23,  32'h20,  m(4),   32'h14,  1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h24,  m(8),   32'h24,  1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h1FC, 32'h1FC, m(8),   32'h24,  1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   m(127), 32'h200, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h205, 32'h4,   m(127), 32'h200, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h8,   m(1),   32'h8,   1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'hC,   m(2),   32'hC,   1'b1};

    #12;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    Rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].pcsrc, vecs[i].target);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].pcp4, vecs[i].vld, 1'b0);
    end

    // Halt at PC=12, ignore stall/flush, leave via redirect to 0
    mem[3] = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 1'b0, 32'h0); step();
    chk_all("halt_cap", 32'hC, 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0); step();
    chk_all("halt_sf", 32'hC, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h0); step();
    chk_all("halt_f", 32'hC, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'h0); step();
    chk_all("halt_redir", 32'h0, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
    mem[3] = m(3);
    drive(1'b0, 1'b0, 1'b0, 32'h0); step();
    chk_all("halt_resume", 32'h4, m(0), 32'h4, 1'b1, 1'b0);

    // Asynchronous reset mid-run
    step();
    chk_all("pre_rst", 32'h8, m(1), 32'h8, 1'b1, 1'b0);
    #3 Rst = 1'b0;
    #1 chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 Rst = 1'b1;
    step();
    chk_all("boot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk_all("boot_cap", 32'h4, m(0), 32'h4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk_all("run5", 32'h14, m(4), 32'h14, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0); step(); step();
    drive(1'b0, 1'b1, 1'b0, 32'h0); step();
    chk_all("perf_seq", 32'h18, m(4), 32'h14, 1'b0, 1'b0);
`ifdef IFU_PERF_CNT_EN
    chk("FetchCount", FetchCount, 32'd5);
    chk("BubbleCount", BubbleCount, 32'd3);
`endif
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // Wrap with a 4-word memory
    #2 Rst2 = 1'b1;
    step();
    chk("wrap boot addr", ImemAddr2, 32'h0);
    chk("wrap boot vld", 32'(InstrValid2), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("wrap addr%0d", i), ImemAddr2, 32'(4 * i));
    end
    step();
    chk("wrap addr4", ImemAddr2, 32'h0);
    chk("wrap instr4", Instruction2, 32'hB000_0003);
    chk("wrap pcp4_4", PCPlus42, 32'h10);
    step();
    chk("wrap addr5", ImemAddr2, 32'h4);
    chk("wrap instr5", Instruction2, 32'hB000_0000);
    chk("wrap pcp4_5", PCPlus42, 32'h4);
    chk("wrap vld5", 32'(InstrValid2), 32'h1);
    chk("wrap halted", 32'(Halted2), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
